// File: rtl/duty_meas_pkg.sv
// Shared types and sizing helpers for the duty-cycle measurement block.
`timescale 1ns/1ps
package duty_meas_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_e;

    localparam int unsigned DEF_EXP_NUM = 3;
    localparam int unsigned DEF_EXP_DEN = 4;

    // Ratio products need 8 extra bits so a counter times an 8-bit ratio term never truncates.
    function automatic int unsigned prod_w(input int unsigned cnt_w);
        return cnt_w + 8;
    endfunction

endpackage

// File: rtl/duty_meas_edge_detect_rise.sv
// Rising-edge detector for a clk-synchronous level.
// The held sample resets to 1 so a level already high at reset release is not an edge.
`timescale 1ns/1ps
module edge_detect_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_d <= 1'b1;
        end else begin
            sig_d <= sig_in;
        end
    end

    assign rise = sig_in & ~sig_d;

endmodule

// File: rtl/duty_cycle_meter.sv
// Measures period and high time of sig_in between consecutive rising edges,
// compares the ratio against EXP_NUM/EXP_DEN and flags an input with no edges.
`timescale 1ns/1ps
module duty_cycle_meter
    import duty_meas_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned EXP_NUM = DEF_EXP_NUM,
    parameter int unsigned EXP_DEN = DEF_EXP_DEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             duty_match,
    output logic             stuck
);

    localparam int unsigned      PROD_W  = prod_w(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e             state;
    logic [CNT_W-1:0]   per_acc;
    logic [CNT_W-1:0]   hi_acc;
    logic               rise;
    logic [PROD_W-1:0]  hi_prod_c;
    logic [PROD_W-1:0]  per_prod_c;
    logic               match_c;

    edge_detect_rise u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rise   (rise)
    );

    // Cross-multiplied ratio compare avoids any division.
    always_comb begin
        hi_prod_c  = PROD_W'(hi_acc)  * PROD_W'(EXP_DEN);
        per_prod_c = PROD_W'(per_acc) * PROD_W'(EXP_NUM);
        match_c    = (hi_prod_c == per_prod_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            per_acc    <= '0;
            hi_acc     <= '0;
            period_cnt <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
            duty_match <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        per_acc <= CNT_ONE;
                        hi_acc  <= CNT_ONE;
                        state   <= MEAS;
                    end
                end
                MEAS: begin
                    // A rise on the timeout cycle still closes the period normally.
                    if (rise) begin
                        period_cnt <= per_acc;
                        high_cnt   <= hi_acc;
                        duty_match <= match_c;
                        meas_valid <= 1'b1;
                        stuck      <= 1'b0;
                        per_acc    <= CNT_ONE;
                        hi_acc     <= CNT_ONE;
                    end else if (per_acc == CNT_MAX) begin
                        stuck   <= 1'b1;
                        per_acc <= '0;
                        hi_acc  <= '0;
                        state   <= IDLE;
                    end else begin
                        per_acc <= per_acc + CNT_ONE;
                        hi_acc  <= hi_acc + CNT_W'(sig_in);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Directed bench for duty_cycle_meter with hand-computed expectations.
`timescale 1ns/1ps
module tb_duty_cycle_meter;

    logic       clk;
    logic       rst_n;
    logic       sig_in;
    logic [7:0] period_cnt;
    logic [7:0] high_cnt;
    logic       meas_valid;
    logic       duty_match;
    logic       stuck;

    int pass_cnt;
    int total_cnt;

    duty_cycle_meter #(.CNT_W(8), .EXP_NUM(3), .EXP_DEN(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .period_cnt (period_cnt),
        .high_cnt   (high_cnt),
        .meas_valid (meas_valid),
        .duty_match (duty_match),
        .stuck      (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input logic s);
        sig_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, 32'(period_cnt), 32'd0);
        chk({tag, "_high"},   32'(high_cnt),   32'd0);
        chk({tag, "_valid"},  32'(meas_valid), 32'd0);
        chk({tag, "_match"},  32'(duty_match), 32'd0);
        chk({tag, "_stuck"},  32'(stuck),      32'd0);
    endtask

    // Drive a repeating pattern; check every valid after the first 'skip' ones, valid spacing,
    // the step index of the first valid, and the total number of valids.
    task automatic run(input string tag, input string pat, input int reps, input int skip,
                       input int exp_n, input int exp_first,
                       input int ep, input int eh, input int em);
        int n;
        int idx;
        int last;
        n    = 0;
        idx  = 0;
        last = -1;
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < pat.len(); i++) begin
                step(pat[i] == "1");
                idx++;
                if (meas_valid) begin
                    n++;
                    if (n == 1) chk({tag, "_first_valid_step"}, 32'(idx), 32'(exp_first));
                    if (last >= 0) chk({tag, "_valid_gap"}, 32'(idx - last), 32'(pat.len()));
                    if (n > skip) begin
                        chk({tag, "_period"}, 32'(period_cnt), 32'(ep));
                        chk({tag, "_high"},   32'(high_cnt),   32'(eh));
                        chk({tag, "_match"},  32'(duty_match), 32'(em));
                    end
                    last = idx;
                end
            end
        end
        chk({tag, "_valid_count"}, 32'(n), 32'(exp_n));
    endtask

    initial begin
        int bad_valid;
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        sig_in    = 1'b0;

        // 1: reset, then 1110 after an explicit low step
        #2;
        chk_zero("t1_in_reset");
        #18;
        rst_n = 1'b1;
        step(1'b0);
        chk_zero("t1_after_release");
        run("t1_1110", "1110", 6, 0, 5, 5, 4, 3, 1);
        chk("t1_stuck", 32'(stuck), 32'd0);

        // 2: 50% duty
        run("t2_1100", "1100", 5, 1, 5, 1, 4, 2, 0);

        // 3: 25% duty, an 8-cycle 3/4 match, and a 9-cycle period
        run("t3_1000", "1000", 5, 1, 5, 1, 4, 1, 0);
        run("t3_8cyc", "11111100", 3, 1, 3, 1, 8, 6, 1);
        run("t3_9cyc", "111111110", 3, 1, 3, 1, 9, 8, 0);

        // 4: one rise then constant low until timeout
        step(1'b1);
        chk("t4_rise_valid", 32'(meas_valid), 32'd1);
        chk("t4_rise_period", 32'(period_cnt), 32'd9);
        bad_valid = 0;
        for (int k = 1; k <= 300; k++) begin
            step(1'b0);
            if (meas_valid) bad_valid++;
            if (k == 254) chk("t4_stuck_before", 32'(stuck), 32'd0);
            if (k == 255) chk("t4_stuck_at", 32'(stuck), 32'd1);
        end
        chk("t4_no_valid", 32'(bad_valid), 32'd0);
        chk("t4_period_hold", 32'(period_cnt), 32'd9);
        chk("t4_high_hold", 32'(high_cnt), 32'd8);
        chk("t4_stuck_sticky", 32'(stuck), 32'd1);
        step(1'b1);
        chk("t4_stuck_after_first_rise", 32'(stuck), 32'd1);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        run("t4_resume", "1110", 2, 0, 2, 1, 4, 3, 1);
        chk("t4_stuck_cleared", 32'(stuck), 32'd0);

        // 5: asynchronous reset mid-period
        step(1'b1);
        step(1'b1);
        chk("t5_pre_period", 32'(period_cnt), 32'd4);
        chk("t5_pre_match", 32'(duty_match), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t5_async");
        step(1'b1);
        step(1'b0);
        chk_zero("t5_held");
        #2;
        rst_n = 1'b1;
        run("t5_after", "1110", 4, 0, 2, 9, 4, 3, 1);

        // 6: input already high at reset release
        rst_n  = 1'b0;
        sig_in = 1'b1;
        #3;
        chk_zero("t6_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        bad_valid = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b1);
            if (meas_valid) bad_valid++;
        end
        chk("t6_no_spurious", 32'(bad_valid), 32'd0);
        chk("t6_period_zero", 32'(period_cnt), 32'd0);
        run("t6_1110", "1110", 4, 0, 2, 9, 4, 3, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
